// File: rtl/vscale_alu_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_alu_arbiter
//
// Purpose:
//   Shares the single vscale ALU between the core pipeline (DX stage) and an
//   auxiliary requester such as a debug or CSR helper. The core normally wins.
//   A starvation counter forces an aux grant after STARVE_MAX consecutive core
//   grants while aux is waiting. Aux results are registered and returned with
//   a one-cycle valid pulse. The core stalls only in the cycle aux is granted.
//
// Ports:
//   clk            - core clock, all state updates on posedge
//   reset          - synchronous, active-high
//   core_req       - DX stage needs the ALU this cycle
//   core_op        - core ALU opcode
//   core_src_a/b   - core operands, already muxed
//   core_stall     - core requested but the ALU went to aux this cycle
//   aux_req        - aux request valid
//   aux_ready      - arbiter can accept an aux request (no aux pending)
//   aux_op/a/b     - aux opcode/operands, sampled on accept
//   aux_resp_valid - one-cycle pulse, aux_resp_data is valid
//   aux_resp_data  - registered ALU result for aux, held until next aux grant
//   alu_op         - opcode to the ALU
//   alu_src_a/b    - operands to the ALU
//   alu_out        - combinational ALU result
// ---------------------------------------------------------------------------
module vscale_alu_arbiter #(
  parameter int STARVE_MAX   = 4,
  parameter int XPR_LEN      = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_req,
  input  logic [ALU_OP_WIDTH-1:0] core_op,
  input  logic [XPR_LEN-1:0]      core_src_a,
  input  logic [XPR_LEN-1:0]      core_src_b,
  output logic                    core_stall,
  input  logic                    aux_req,
  output logic                    aux_ready,
  input  logic [ALU_OP_WIDTH-1:0] aux_op,
  input  logic [XPR_LEN-1:0]      aux_a,
  input  logic [XPR_LEN-1:0]      aux_b,
  output logic                    aux_resp_valid,
  output logic [XPR_LEN-1:0]      aux_resp_data,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [XPR_LEN-1:0]      alu_src_a,
  output logic [XPR_LEN-1:0]      alu_src_b,
  input  logic [XPR_LEN-1:0]      alu_out
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [CNT_W-1:0]        r_starveCnt;
  logic [CNT_W-1:0]        w_starveCntNext;
  logic [ALU_OP_WIDTH-1:0] r_auxOp;
  logic [XPR_LEN-1:0]      r_auxA;
  logic [XPR_LEN-1:0]      r_auxB;
  logic                    r_respValid;
  logic [XPR_LEN-1:0]      r_respData;
  logic                    w_accept;
  logic                    w_auxGnt;

  // State and starvation counter registers; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_starveCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_starveCnt <= w_starveCntNext;
    end
  end

  // Grant decision, ALU mux, next state and counter update.
  // Aux wins when the core is idle or once the core has been granted
  // STARVE_MAX times in a row while aux was waiting. Because the grant is
  // forced at the limit, the increment can never overflow past STARVE_LIM.
  always_comb begin
    w_accept        = 1'b0;
    w_auxGnt        = 1'b0;
    w_stateNext     = r_state;
    w_starveCntNext = '0;
    aux_ready       = (r_state == ST_IDLE);
    alu_op          = core_op;
    alu_src_a       = core_src_a;
    alu_src_b       = core_src_b;

    w_accept = aux_req && (r_state == ST_IDLE);
    w_auxGnt = (r_state == ST_PEND) && ((r_starveCnt == STARVE_LIM) || !core_req);

    if (w_auxGnt) begin
      alu_op    = r_auxOp;
      alu_src_a = r_auxA;
      alu_src_b = r_auxB;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_stateNext = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_auxGnt) begin
          w_stateNext = ST_IDLE;
        end else if (core_req) begin
          w_starveCntNext = r_starveCnt + CNT_W'(1);
        end else begin
          w_starveCntNext = r_starveCnt;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    core_stall = core_req && w_auxGnt;
  end

  // Aux operands are captured only in the accept cycle so the requester
  // may change its inputs freely while the request is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_auxOp <= '0;
      r_auxA  <= '0;
      r_auxB  <= '0;
    end else if (w_accept) begin
      r_auxOp <= aux_op;
      r_auxA  <= aux_a;
      r_auxB  <= aux_b;
    end
  end

  // Aux response: valid pulses for one cycle after the grant, data holds
  // until the next aux grant overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respData  <= '0;
    end else begin
      r_respValid <= w_auxGnt;
      if (w_auxGnt) begin
        r_respData <= alu_out;
      end
    end
  end

  assign aux_resp_valid = r_respValid;
  assign aux_resp_data  = r_respData;

endmodule

// File: tb/tb_vscale_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vscale_alu_arbiter
//
// Purpose:
//   Self-checking bench for vscale_alu_arbiter. A small behavioural ALU model
//   closes the loop on alu_out. Inputs change just after each negedge and
//   outputs are checked 1 ns later, well away from the posedge.
// ---------------------------------------------------------------------------
module tb_vscale_alu_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int XL = 32;
  localparam int OW = 4;

  localparam logic [OW-1:0] OP_ADD = 4'd0;
  localparam logic [OW-1:0] OP_XOR = 4'd4;
  localparam logic [OW-1:0] OP_OR  = 4'd6;
  localparam logic [OW-1:0] OP_AND = 4'd7;
  localparam logic [OW-1:0] OP_SUB = 4'd10;

  logic          clk;
  logic          reset;
  logic          core_req;
  logic [OW-1:0] core_op;
  logic [XL-1:0] core_src_a;
  logic [XL-1:0] core_src_b;
  logic          core_stall;
  logic          aux_req;
  logic          aux_ready;
  logic [OW-1:0] aux_op;
  logic [XL-1:0] aux_a;
  logic [XL-1:0] aux_b;
  logic          aux_resp_valid;
  logic [XL-1:0] aux_resp_data;
  logic [OW-1:0] alu_op;
  logic [XL-1:0] alu_src_a;
  logic [XL-1:0] alu_src_b;
  logic [XL-1:0] alu_out;

  int nChecks = 0;
  int nFails  = 0;

  vscale_alu_arbiter #(
    .STARVE_MAX  (STARVE_MAX),
    .XPR_LEN     (XL),
    .ALU_OP_WIDTH(OW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_req      (core_req),
    .core_op       (core_op),
    .core_src_a    (core_src_a),
    .core_src_b    (core_src_b),
    .core_stall    (core_stall),
    .aux_req       (aux_req),
    .aux_ready     (aux_ready),
    .aux_op        (aux_op),
    .aux_a         (aux_a),
    .aux_b         (aux_b),
    .aux_resp_valid(aux_resp_valid),
    .aux_resp_data (aux_resp_data),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_out       (alu_out)
  );

  // Clock generation, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the vscale ALU.
  function automatic logic [XL-1:0] aluFn(input logic [OW-1:0] op, input logic [XL-1:0] a,
                                          input logic [XL-1:0] b);
    case (op)
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SUB:  return a - b;
      default: return a + b;
    endcase
  endfunction

  assign alu_out = aluFn(alu_op, alu_src_a, alu_src_b);

  function automatic logic [OW-1:0] randOp();
    case ($urandom_range(0, 4))
      0:       return OP_ADD;
      1:       return OP_XOR;
      2:       return OP_OR;
      3:       return OP_AND;
      default: return OP_SUB;
    endcase
  endfunction

  // Quiesce all inputs.
  task automatic idleInputs();
    core_req   = 1'b0;
    core_op    = OP_ADD;
    core_src_a = '0;
    core_src_b = '0;
    aux_req    = 1'b0;
    aux_op     = OP_ADD;
    aux_a      = '0;
    aux_b      = '0;
  endtask

  // Reset state: ready, no response, zeroed data, ALU follows core inputs.
  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    core_op    = OP_OR;
    core_src_a = 32'h55;
    core_src_b = 32'h0F;
    repeat (2) @(negedge clk);
    #1;
    nChecks++;
    if (aux_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL reset_ready got=%b want=1", aux_ready);
    end
    nChecks++;
    if (aux_resp_valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_valid got=%b want=0", aux_resp_valid);
    end
    nChecks++;
    if (aux_resp_data !== 32'h0) begin
      nFails++; $display("[TB] FAIL reset_data got=%h want=0", aux_resp_data);
    end
    nChecks++;
    if (core_stall !== 1'b0) begin
      nFails++; $display("[TB] FAIL reset_stall got=%b want=0", core_stall);
    end
    nChecks++;
    if (alu_src_a !== 32'h55 || alu_op !== OP_OR) begin
      nFails++; $display("[TB] FAIL reset_alu got=%h/%0d want=55/6", alu_src_a, alu_op);
    end
    @(negedge clk);
    reset = 1'b0;
    idleInputs();
    @(negedge clk);
  endtask

  // T1: idle core, aux ADD 5+7 -> grant cyc1, response 12 at cyc2.
  task automatic test_idle_core();
    idleInputs();
    aux_req = 1'b1; aux_op = OP_ADD; aux_a = 32'd5; aux_b = 32'd7;
    #1;
    nChecks++;
    if (aux_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL t1_ready_c0 got=%b want=1", aux_ready);
    end
    @(negedge clk);
    aux_req = 1'b0; aux_a = 32'hDEAD; aux_b = 32'hBEEF; aux_op = OP_XOR;
    #1;
    nChecks++;
    if (alu_op !== OP_ADD || alu_src_a !== 32'd5 || alu_src_b !== 32'd7) begin
      nFails++;
      $display("[TB] FAIL t1_alu_c1 got=%0d/%h/%h want=0/5/7", alu_op, alu_src_a, alu_src_b);
    end
    nChecks++;
    if (aux_ready !== 1'b0 || core_stall !== 1'b0 || aux_resp_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL t1_flags_c1 got=rdy%b stall%b vld%b want=000", aux_ready, core_stall,
               aux_resp_valid);
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (aux_resp_valid !== 1'b1 || aux_resp_data !== 32'd12) begin
      nFails++;
      $display("[TB] FAIL t1_resp_c2 got=%b/%0d want=1/12", aux_resp_valid, aux_resp_data);
    end
    nChecks++;
    if (aux_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL t1_ready_c2 got=%b want=1", aux_ready);
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (aux_resp_valid !== 1'b0 || aux_resp_data !== 32'd12) begin
      nFails++;
      $display("[TB] FAIL t1_hold_c3 got=%b/%0d want=0/12", aux_resp_valid, aux_resp_data);
    end
    @(negedge clk);
  endtask

  // T2: core busy every cycle; aux must wait exactly STARVE_MAX core grants.
  task automatic test_starvation();
    idleInputs();
    core_req = 1'b1; core_op = OP_XOR; core_src_a = 32'h100; core_src_b = 32'h1;
    aux_req = 1'b1; aux_op = OP_SUB; aux_a = 32'd20; aux_b = 32'd3;
    for (int c = 0; c <= 6; c++) begin
      #1;
      if (c >= 1 && c <= 4) begin
        nChecks++;
        if (alu_src_a !== 32'h100 || alu_op !== OP_XOR || core_stall !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL t2_core_c%0d got=%h/%0d stall%b want=100/4 stall0", c, alu_src_a,
                   alu_op, core_stall);
        end
      end else if (c == 5) begin
        nChecks++;
        if (alu_src_a !== 32'd20 || alu_src_b !== 32'd3 || alu_op !== OP_SUB ||
            core_stall !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL t2_aux_c5 got=%h/%h/%0d stall%b want=14/3/10 stall1", alu_src_a,
                   alu_src_b, alu_op, core_stall);
        end
      end else begin
        nChecks++;
        if (core_stall !== 1'b0) begin
          nFails++; $display("[TB] FAIL t2_stall_c%0d got=%b want=0", c, core_stall);
        end
      end
      nChecks++;
      if (aux_resp_valid !== (c == 6)) begin
        nFails++;
        $display("[TB] FAIL t2_valid_c%0d got=%b want=%b", c, aux_resp_valid, (c == 6));
      end
      if (c == 6) begin
        nChecks++;
        if (aux_resp_data !== 32'd17) begin
          nFails++; $display("[TB] FAIL t2_data got=%0d want=17", aux_resp_data);
        end
      end
      @(negedge clk);
      aux_req = 1'b0;
    end
    idleInputs();
    @(negedge clk);
  endtask

  // T3: core passthrough, then 100 random core cycles without aux.
  task automatic test_passthrough();
    idleInputs();
    core_req = 1'b1; core_op = OP_SUB; core_src_a = 32'h10; core_src_b = 32'h3;
    #1;
    nChecks++;
    if (alu_op !== OP_SUB || alu_src_a !== 32'h10 || alu_src_b !== 32'h3 ||
        core_stall !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL t3_pass got=%0d/%h/%h stall%b want=10/10/3 stall0", alu_op, alu_src_a,
               alu_src_b, core_stall);
    end
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      core_req   = 1'($urandom_range(0, 1));
      core_op    = randOp();
      core_src_a = $urandom;
      core_src_b = $urandom;
      #1;
      nChecks++;
      if (core_stall !== 1'b0 || alu_src_a !== core_src_a || alu_src_b !== core_src_b ||
          alu_op !== core_op) begin
        nFails++;
        $display("[TB] FAIL t3_rand%0d stall=%b alu=%h/%h want stall0 %h/%h", i, core_stall,
                 alu_src_a, alu_src_b, core_src_a, core_src_b);
      end
      @(negedge clk);
    end
    idleInputs();
    @(negedge clk);
  endtask

  // T4: aux_req held high; second request accepted in the response cycle.
  task automatic test_back_to_back();
    idleInputs();
    aux_req = 1'b1; aux_op = OP_ADD; aux_a = 32'd9; aux_b = 32'd1;
    @(negedge clk);
    aux_a = 32'd2; aux_b = 32'd2;
    #1;
    nChecks++;
    if (alu_src_a !== 32'd9 || alu_src_b !== 32'd1 || aux_ready !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL t4_first_c1 got=%0d/%0d rdy%b want=9/1 rdy0", alu_src_a, alu_src_b,
               aux_ready);
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (aux_resp_valid !== 1'b1 || aux_resp_data !== 32'd10 || aux_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL t4_resp1_c2 got=%b/%0d rdy%b want=1/10 rdy1", aux_resp_valid,
               aux_resp_data, aux_ready);
    end
    @(negedge clk);
    aux_req = 1'b0;
    #1;
    nChecks++;
    if (alu_src_a !== 32'd2 || alu_src_b !== 32'd2 || aux_resp_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL t4_second_c3 got=%0d/%0d vld%b want=2/2 vld0", alu_src_a, alu_src_b,
               aux_resp_valid);
    end
    @(negedge clk);
    #1;
    nChecks++;
    if (aux_resp_valid !== 1'b1 || aux_resp_data !== 32'd4) begin
      nFails++;
      $display("[TB] FAIL t4_resp2_c4 got=%b/%0d want=1/4", aux_resp_valid, aux_resp_data);
    end
    @(negedge clk);
  endtask

  // T5: reset while aux pending drops it; a fresh request then completes.
  task automatic test_reset_mid_op();
    idleInputs();
    core_req = 1'b1; core_src_a = 32'h77;
    aux_req = 1'b1; aux_op = OP_ADD; aux_a = 32'd3; aux_b = 32'd4;
    @(negedge clk);
    aux_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    nChecks++;
    if (aux_ready !== 1'b1 || aux_resp_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL t5_after_reset got=rdy%b vld%b want=rdy1 vld0", aux_ready,
               aux_resp_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      nChecks++;
      if (aux_resp_valid !== 1'b0 || core_stall !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL t5_dropped%0d got=vld%b stall%b want=0/0", i, aux_resp_valid,
                 core_stall);
      end
    end
    @(negedge clk);
    aux_req = 1'b1; aux_op = OP_AND; aux_a = 32'hF0F0; aux_b = 32'h0FF0;
    for (int c = 0; c <= 6; c++) begin
      #1;
      nChecks++;
      if (core_stall !== (c == 5)) begin
        nFails++; $display("[TB] FAIL t5_stall_c%0d got=%b want=%b", c, core_stall, (c == 5));
      end
      if (c == 6) begin
        nChecks++;
        if (aux_resp_valid !== 1'b1 || aux_resp_data !== 32'h00F0) begin
          nFails++;
          $display("[TB] FAIL t5_resp got=%b/%h want=1/000000f0", aux_resp_valid, aux_resp_data);
        end
      end
      @(negedge clk);
      aux_req = 1'b0;
    end
    idleInputs();
    @(negedge clk);
  endtask

  // T6: random traffic against a cycle-level scoreboard model.
  task automatic test_random();
    logic          mPend = 1'b0;
    int            mCnt = 0;
    logic [OW-1:0] mOp = '0;
    logic [XL-1:0] mA = '0;
    logic [XL-1:0] mB = '0;
    logic          mRespValid = 1'b0;
    logic [XL-1:0] mRespData = aux_resp_data;
    logic          gnt;
    logic [OW-1:0] eOp;
    logic [XL-1:0] eA;
    logic [XL-1:0] eB;
    int            outAge = -1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      core_req   = ($urandom_range(0, 3) != 0);
      core_op    = randOp();
      core_src_a = $urandom;
      core_src_b = $urandom;
      aux_req    = 1'($urandom_range(0, 1));
      aux_op     = randOp();
      aux_a      = $urandom;
      aux_b      = $urandom;
      #1;
      gnt = mPend && (mCnt == STARVE_MAX || !core_req);
      eOp = gnt ? mOp : core_op;
      eA  = gnt ? mA  : core_src_a;
      eB  = gnt ? mB  : core_src_b;
      nChecks++;
      if (alu_op !== eOp || alu_src_a !== eA || alu_src_b !== eB) begin
        nFails++;
        $display("[TB] FAIL t6_alu cyc%0d got=%0d/%h/%h want=%0d/%h/%h", cyc, alu_op, alu_src_a,
                 alu_src_b, eOp, eA, eB);
      end
      nChecks++;
      if (core_stall !== (core_req && gnt) || aux_ready !== !mPend) begin
        nFails++;
        $display("[TB] FAIL t6_ctl cyc%0d got=stall%b rdy%b want=stall%b rdy%b", cyc, core_stall,
                 aux_ready, (core_req && gnt), !mPend);
      end
      nChecks++;
      if (aux_resp_valid !== mRespValid || aux_resp_data !== mRespData) begin
        nFails++;
        $display("[TB] FAIL t6_resp cyc%0d got=%b/%h want=%b/%h", cyc, aux_resp_valid,
                 aux_resp_data, mRespValid, mRespData);
      end
      // Latency watchdog driven purely by observed handshakes.
      if (aux_resp_valid === 1'b1 && outAge >= 0) begin
        nChecks++;
        if (outAge > STARVE_MAX + 2) begin
          nFails++;
          $display("[TB] FAIL t6_latency cyc%0d got=%0d want<=%0d", cyc, outAge, STARVE_MAX + 2);
        end
        outAge = -1;
      end else if (outAge > STARVE_MAX + 2) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL t6_timeout cyc%0d got=no_resp want=resp_within_%0d", cyc,
                 STARVE_MAX + 2);
        outAge = -1;
      end
      if (outAge >= 0) outAge++;
      if (aux_req === 1'b1 && aux_ready === 1'b1) outAge = 1;
      // Advance the model to the state after this posedge.
      mRespValid = gnt;
      if (gnt) mRespData = aluFn(mOp, mA, mB);
      if (gnt) begin
        mPend = 1'b0;
        mCnt  = 0;
      end else if (mPend) begin
        if (core_req) mCnt++;
      end else begin
        mCnt = 0;
        if (aux_req) begin
          mPend = 1'b1;
          mOp   = aux_op;
          mA    = aux_a;
          mB    = aux_b;
        end
      end
      @(negedge clk);
    end
    idleInputs();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    $display("[TB] start");
    test_reset();
    test_idle_core();
    test_starvation();
    test_passthrough();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
